lfsr_prbs_checker: RTL and testbench

Self-synchronizing PRBS checker for receive-side link test paths. It takes a parallel word stream that should carry an LFSR-generated PRBS sequence, such as PRBS31. For each word it reports a per-bit error mask one cycle later. Its internal state is loaded from the received bits, not from its own predictions, so it locks to any correct stream within LFSR_WIDTH bits without seed alignment.

---
 rtl/lfsr_pkg.sv | 43 ++++
 rtl/lfsr.sv | 64 ++++++
 rtl/lfsr_prbs_checker.sv | 68 ++++++
 tb/tb_lfsr_prbs_checker.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/lfsr_pkg.sv
// Shared constants and mask-matrix helper for the PRBS checker.
//
// lfsr_mask() symbolically runs the bit-serial Fibonacci recurrence over
// DATA_WIDTH steps. It returns one row of the combined XOR matrix. Columns
// [W-1:0] select state bits and columns [W+D-1:W] select data bits.
//   row <  W : next-state bit `row`
//   row >= W : error bit `row-W`
package lfsr_pkg;

  localparam string STYLE_AUTO      = "AUTO";
  localparam string STYLE_LOOP      = "LOOP";
  localparam string STYLE_REDUCTION = "REDUCTION";
  localparam string CFG_FIB_FF      = "FIBONACCI_FF";

  localparam int MAX_W    = 64;
  localparam int MAX_D    = 64;
  localparam int MAX_BITS = MAX_W + MAX_D;

  typedef logic [MAX_W-1:0]    poly_t;
  typedef logic [MAX_BITS-1:0] mask_t;

  function automatic mask_t lfsr_mask(input poly_t poly, input int width,
                                      input int reverse, input int dwidth,
                                      input int row);
    mask_t st [MAX_W];
    mask_t e  [MAX_D];
    mask_t r, p;
    int    k;
    for (int i = 0; i < MAX_W; i++) st[i] = (i < width) ? (mask_t'(1) << i) : '0;
    for (int i = 0; i < MAX_D; i++) e[i] = '0;
    for (int s = 0; s < dwidth; s++) begin
      k = (reverse != 0) ? s : dwidth - 1 - s;
      r = mask_t'(1) << (width + k);
      p = st[width-1];
      for (int j = 1; j < width; j++) if (poly[j]) p = p ^ st[j-1];
      e[k] = r ^ p;
      for (int i = width - 1; i > 0; i--) st[i] = st[i-1];
      st[0] = r;
    end
    return (row < width) ? st[row] : e[row-width];
  endfunction

endpackage

// File: rtl/lfsr.sv
// Combinational DATA_WIDTH-step unroll of a feed-forward Fibonacci checker.
//   data_in   : received bits, already de-inverted
//   state_in  : current history of received bits (state_in[0] newest)
//   data_out  : per-bit error mask
//   state_out : history after shifting in all of data_in
module lfsr
  import lfsr_pkg::*;
#(
  parameter int                  LFSR_WIDTH  = 31,
  parameter logic [LFSR_WIDTH-1:0] LFSR_POLY = 31'h10000001,
  parameter string               LFSR_CONFIG = "FIBONACCI_FF",
  parameter int                  REVERSE     = 0,
  parameter int                  DATA_WIDTH  = 8,
  parameter string               STYLE       = "AUTO"
) (
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic [LFSR_WIDTH-1:0] state_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic [LFSR_WIDTH-1:0] state_out
);

  if (LFSR_CONFIG != CFG_FIB_FF) begin : g_bad_cfg
    $error("lfsr: unsupported LFSR_CONFIG");
  end
  if (STYLE != STYLE_AUTO && STYLE != STYLE_LOOP && STYLE != STYLE_REDUCTION) begin : g_bad_style
    $error("lfsr: unsupported STYLE");
  end

  if (STYLE == STYLE_LOOP) begin : g_loop
    logic [LFSR_WIDTH-1:0] st;
    logic [DATA_WIDTH-1:0] e;
    logic                  r, p;
    always_comb begin
      st = state_in;
      e  = '0;
      r  = 1'b0;
      p  = 1'b0;
      for (int s = 0; s < DATA_WIDTH; s++) begin
        r = data_in[(REVERSE != 0) ? s : DATA_WIDTH-1-s];
        p = st[LFSR_WIDTH-1];
        for (int j = 1; j < LFSR_WIDTH; j++) if (LFSR_POLY[j]) p = p ^ st[j-1];
        e[(REVERSE != 0) ? s : DATA_WIDTH-1-s] = r ^ p;
        // The received bit is shifted in, which is what makes it self-synchronizing.
        st = {st[LFSR_WIDTH-2:0], r};
      end
    end
    assign data_out  = e;
    assign state_out = st;
  end else begin : g_red
    // Each output bit is the parity of a constant subset of {data, state}.
    logic [LFSR_WIDTH+DATA_WIDTH-1:0] vec;
    assign vec = {data_in, state_in};
    for (genvar i = 0; i < LFSR_WIDTH + DATA_WIDTH; i++) begin : g_row
      localparam mask_t M = lfsr_mask(poly_t'(LFSR_POLY), LFSR_WIDTH, REVERSE,
                                      DATA_WIDTH, i);
      if (i < LFSR_WIDTH) begin : g_st
        assign state_out[i] = ^(vec & M[LFSR_WIDTH+DATA_WIDTH-1:0]);
      end else begin : g_err
        assign data_out[i-LFSR_WIDTH] = ^(vec & M[LFSR_WIDTH+DATA_WIDTH-1:0]);
      end
    end
  end

endmodule

// File: rtl/lfsr_prbs_checker.sv
// Self-synchronizing PRBS checker. It reports a per-bit error mask for each
// valid word one cycle after sampling.
//   clk           : clock
//   rst           : asynchronous reset, active low
//   data_in       : received word
//   data_in_valid : data_in is valid this cycle
//   data_out      : error mask of the last valid word (1 = bit wrong)
module lfsr_prbs_checker
  import lfsr_pkg::*;
#(
  parameter int                    LFSR_WIDTH  = 31,
  parameter logic [LFSR_WIDTH-1:0] LFSR_POLY   = 31'h10000001,
  parameter logic [LFSR_WIDTH-1:0] LFSR_INIT   = '1,
  parameter string                 LFSR_CONFIG = "FIBONACCI_FF",
  parameter int                    REVERSE     = 0,
  parameter int                    INVERT      = 1,
  parameter int                    DATA_WIDTH  = 8,
  parameter string                 STYLE       = "AUTO"
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  data_in_valid,
  output logic [DATA_WIDTH-1:0] data_out
);

  logic [LFSR_WIDTH-1:0] state_q, state_d, state_nxt;
  logic [DATA_WIDTH-1:0] err_q, err_d, err_nxt;
  logic [DATA_WIDTH-1:0] rx;

  assign rx = data_in ^ {DATA_WIDTH{INVERT != 0}};

  lfsr #(
    .LFSR_WIDTH (LFSR_WIDTH),
    .LFSR_POLY  (LFSR_POLY),
    .LFSR_CONFIG(LFSR_CONFIG),
    .REVERSE    (REVERSE),
    .DATA_WIDTH (DATA_WIDTH),
    .STYLE      (STYLE)
  ) u_lfsr (
    .data_in  (rx),
    .state_in (state_q),
    .data_out (err_nxt),
    .state_out(state_nxt)
  );

  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    if (data_in_valid) begin
      state_d = state_nxt;
      err_d   = err_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= LFSR_INIT;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
    end
  end

  assign data_out = err_q;

endmodule

// File: tb/tb_lfsr_prbs_checker.sv
module tb_lfsr_prbs_checker;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] din;
  logic       vld;
  logic [7:0] dout;

  int errors = 0;
  int checks = 0;

  // Reference: history of received (de-inverted) bits, newest at the back.
  bit       hist[$];
  bit       gh[$];
  bit [7:0] exp_mask;

  always #5 clk = ~clk;

  lfsr_prbs_checker dut (
    .clk          (clk),
    .rst          (rst),
    .data_in      (din),
    .data_in_valid(vld),
    .data_out     (dout)
  );

  initial begin
    #2000000;
    $display("FAIL timeout: got no finish, want finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%02h want 0x%02h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    hist.delete();
    for (int i = 0; i < 31; i++) hist.push_back(1'b1);
    exp_mask = '0;
  endtask

  // PRBS31: each bit should equal the bit 31 ago XOR the bit 28 ago.
  task automatic model_word(input bit [7:0] d);
    bit r, p;
    for (int s = 0; s < 8; s++) begin
      r = ~d[7-s];
      p = hist[hist.size()-31] ^ hist[hist.size()-28];
      exp_mask[7-s] = r ^ p;
      hist.push_back(r);
      void'(hist.pop_front());
    end
  endtask

  task automatic gen_seed(input bit [30:0] seed);
    gh.delete();
    for (int i = 0; i < 31; i++) gh.push_back(seed[i]);
  endtask

  function automatic bit [7:0] gen_word();
    bit [7:0] w;
    bit g;
    for (int s = 0; s < 8; s++) begin
      g = gh[gh.size()-31] ^ gh[gh.size()-28];
      gh.push_back(g);
      void'(gh.pop_front());
      w[7-s] = ~g;
    end
    return w;
  endfunction

  // Drive one cycle, then check against the model just after the edge.
  task automatic step(input bit [7:0] d, input bit v);
    din = d;
    vld = v;
    @(posedge clk);
    #1;
    if (v) model_word(d);
    chk("model", dout, exp_mask);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    vld = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    chk("reset_dout", dout, 8'h00);
    rst = 1'b1;
  endtask

  initial begin
    bit [7:0]  w, held;
    bit [30:0] seed;
    rst = 1'b0;
    vld = 1'b0;
    din = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    step(8'hFF, 1'b1);
    chk("init_ff", dout, 8'h00);

    do_reset();
    step(8'h00, 1'b1);
    chk("init_00", dout, 8'hFF);

    // Clean stream from the checker's own init value
    do_reset();
    gen_seed('1);
    for (int i = 0; i < 1000; i++) begin
      step(gen_word(), 1'b1);
      chk("clean", dout, 8'h00);
    end

    // Arbitrary seed with a single flipped bit in word 10
    do_reset();
    seed = 31'($urandom());
    if (seed == '0) seed = 31'h1;
    gen_seed(seed);
    for (int i = 0; i < 40; i++) begin
      w = gen_word();
      if (i == 10) w = w ^ 8'h80;
      step(w, 1'b1);
      if (i >= 4) chk("flip", dout, (i == 10) ? 8'h80 : (i == 13) ? 8'h09 : 8'h00);
    end

    // Leave a nonzero mask, then idle: output must hold
    step(gen_word() ^ 8'h01, 1'b1);
    held = exp_mask;
    for (int i = 0; i < 5; i++) begin
      step(8'($urandom()), 1'b0);
      chk("hold", dout, held);
    end
    for (int i = 0; i < 8; i++) begin
      w = gen_word();
      step(w, 1'b1);
      if (i >= 4) chk("after_idle", dout, 8'h00);
    end

    // Asynchronous reset between edges
    do_reset();
    step(8'h00, 1'b1);
    #3;
    rst = 1'b0;
    #1;
    chk("async_rst", dout, 8'h00);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    step(8'hFF, 1'b1);
    chk("rst_restart", dout, 8'h00);

    // Random words and valid pattern
    for (int i = 0; i < 300; i++) step(8'($urandom()), 1'($urandom_range(0, 1)));

    // Random valid pattern over a correct stream
    do_reset();
    gen_seed('1);
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 3) == 0) step(8'($urandom()), 1'b0);
      else begin
        step(gen_word(), 1'b1);
        chk("gapped", dout, 8'h00);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
